// File: rtl/mem_lsu_if.sv
// mem_lsu_if: bundles the signals of the memory-stage load/store unit.
// It carries the EX-side offer handshake, the SRAM-like data bus
// (req/addr_ok/data_ok) and the register-file write-back port.
// The "slave" modport is the LSU's view of these signals.
// The "master" modport is the view of the surrounding core, bus and bench.
interface mem_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_sdata;
  logic [4:0]  in_dest;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_strb;
  logic        done;
  logic        adel;
  logic        ades;

  modport slave (
    input  in_valid, in_op, in_addr, in_sdata, in_dest,
           data_addr_ok, data_data_ok, data_rdata,
    output in_ready, data_req, data_wr, data_size, data_addr, data_wdata,
           data_wstrb, wb_wen, wb_waddr, wb_wdata, wb_strb, done, adel, ades
  );

  modport master (
    output in_valid, in_op, in_addr, in_sdata, in_dest,
           data_addr_ok, data_data_ok, data_rdata,
    input  in_ready, data_req, data_wr, data_size, data_addr, data_wdata,
           data_wstrb, wb_wen, wb_waddr, wb_wdata, wb_strb, done, adel, ades
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit with one outstanding transaction.
// It accepts one op from EX and issues it on the SRAM-like data bus.
// Returned load data is aligned and written back with a byte strobe, so the
// register file can merge partial writes.
// Define LSU_UNALIGNED_EN to decode LWL/LWR/SWL/SWR. Without it those codes
// are illegal no-ops: done only, with no bus access and no write-back.
module mem_lsu (
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.slave lsu_io
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
`ifdef LSU_UNALIGNED_EN
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [1:0]  boff_q;
  logic [4:0]  dest_q;
  logic        ready_q;
  logic        req_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [31:0] wbData_q;
  logic [3:0]  wbStrb_q;
  logic        done_q;
  logic        adel_q;
  logic        ades_q;

  logic        legal_d;
  logic        load_d;
  logic        store_d;
  logic        misaligned_d;
  logic [1:0]  size_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] ldData_d;
  logic [3:0]  ldStrb_d;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [1:0]  inOff;

  assign inOff = lsu_io.in_addr[1:0];

  // Decode the offered op into legality, fault status and bus request fields
  always_comb begin
    legal_d      = 1'b0;
    load_d       = 1'b0;
    store_d      = 1'b0;
    misaligned_d = 1'b0;
    size_d       = 2'd2;
    addr_d       = {lsu_io.in_addr[31:2], 2'b00};
    wdata_d      = lsu_io.in_sdata;
    wstrb_d      = 4'b0000;
    case (lsu_io.in_op)
      OP_LB, OP_LBU: begin
        legal_d = 1'b1;
        load_d  = 1'b1;
        size_d  = 2'd0;
        addr_d  = lsu_io.in_addr;
      end
      OP_LH, OP_LHU: begin
        legal_d      = 1'b1;
        load_d       = 1'b1;
        size_d       = 2'd1;
        addr_d       = lsu_io.in_addr;
        misaligned_d = inOff[0];
      end
      OP_LW: begin
        legal_d      = 1'b1;
        load_d       = 1'b1;
        misaligned_d = |inOff;
      end
      OP_SB: begin
        legal_d = 1'b1;
        store_d = 1'b1;
        size_d  = 2'd0;
        addr_d  = lsu_io.in_addr;
        wdata_d = {4{lsu_io.in_sdata[7:0]}};
        wstrb_d = 4'b0001 << inOff;
      end
      OP_SH: begin
        legal_d      = 1'b1;
        store_d      = 1'b1;
        size_d       = 2'd1;
        addr_d       = lsu_io.in_addr;
        wdata_d      = {2{lsu_io.in_sdata[15:0]}};
        wstrb_d      = inOff[1] ? 4'b1100 : 4'b0011;
        misaligned_d = inOff[0];
      end
      OP_SW: begin
        legal_d      = 1'b1;
        store_d      = 1'b1;
        wstrb_d      = 4'b1111;
        misaligned_d = |inOff;
      end
`ifdef LSU_UNALIGNED_EN
      OP_LWL, OP_LWR: begin
        legal_d = 1'b1;
        load_d  = 1'b1;
      end
      OP_SWL: begin
        legal_d = 1'b1;
        store_d = 1'b1;
        wdata_d = lsu_io.in_sdata >> {2'd3 - inOff, 3'b000};
        wstrb_d = 4'b1111 >> (2'd3 - inOff);
      end
      OP_SWR: begin
        legal_d = 1'b1;
        store_d = 1'b1;
        wdata_d = lsu_io.in_sdata << {inOff, 3'b000};
        wstrb_d = 4'b1111 << inOff;
      end
`endif
      default: ;
    endcase
  end

  // Align returned read data into register lanes and pick the merge strobe
  always_comb begin
    ldByte   = lsu_io.data_rdata[{boff_q, 3'b000} +: 8];
    ldHalf   = boff_q[1] ? lsu_io.data_rdata[31:16] : lsu_io.data_rdata[15:0];
    ldData_d = lsu_io.data_rdata;
    ldStrb_d = 4'b1111;
    case (op_q)
      OP_LB:   ldData_d = {{24{ldByte[7]}}, ldByte};
      OP_LBU:  ldData_d = {24'd0, ldByte};
      OP_LH:   ldData_d = {{16{ldHalf[15]}}, ldHalf};
      OP_LHU:  ldData_d = {16'd0, ldHalf};
`ifdef LSU_UNALIGNED_EN
      OP_LWL: begin
        ldData_d = lsu_io.data_rdata << {2'd3 - boff_q, 3'b000};
        ldStrb_d = 4'b1111 << (2'd3 - boff_q);
      end
      OP_LWR: begin
        ldData_d = lsu_io.data_rdata >> {boff_q, 3'b000};
        ldStrb_d = 4'b1111 >> boff_q;
      end
`endif
      default: ;
    endcase
  end

  // Transaction FSM; every interface output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'd0;
      boff_q   <= 2'd0;
      dest_q   <= 5'd0;
      ready_q  <= 1'b1;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      wen_q    <= 1'b0;
      waddr_q  <= 5'd0;
      wbData_q <= 32'd0;
      wbStrb_q <= 4'd0;
      done_q   <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lsu_io.in_valid) begin
            ready_q <= 1'b0;
            op_q    <= lsu_io.in_op;
            boff_q  <= inOff;
            dest_q  <= lsu_io.in_dest;
            if (!legal_d) begin
              done_q  <= 1'b1;
              state_q <= ST_RESP;
            end else if (misaligned_d) begin
              done_q  <= 1'b1;
              adel_q  <= load_d;
              ades_q  <= store_d;
              state_q <= ST_RESP;
            end else begin
              req_q   <= 1'b1;
              wr_q    <= store_d;
              size_q  <= size_d;
              addr_q  <= addr_d;
              wdata_q <= wdata_d;
              wstrb_q <= wstrb_d;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (lsu_io.data_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lsu_io.data_data_ok) begin
            done_q  <= 1'b1;
            state_q <= ST_RESP;
            if (!op_q[3] && dest_q != 5'd0) begin
              wen_q    <= 1'b1;
              waddr_q  <= dest_q;
              wbData_q <= ldData_d;
              wbStrb_q <= ldStrb_d;
            end
          end
        end
        ST_RESP: begin
          done_q  <= 1'b0;
          adel_q  <= 1'b0;
          ades_q  <= 1'b0;
          wen_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lsu_io.in_ready   = ready_q;
  assign lsu_io.data_req   = req_q;
  assign lsu_io.data_wr    = wr_q;
  assign lsu_io.data_size  = size_q;
  assign lsu_io.data_addr  = addr_q;
  assign lsu_io.data_wdata = wdata_q;
  assign lsu_io.data_wstrb = wstrb_q;
  assign lsu_io.wb_wen     = wen_q;
  assign lsu_io.wb_waddr   = waddr_q;
  assign lsu_io.wb_wdata   = wbData_q;
  assign lsu_io.wb_strb    = wbStrb_q;
  assign lsu_io.done       = done_q;
  assign lsu_io.adel       = adel_q;
  assign lsu_io.ades       = ades_q;

endmodule
